// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and buffered fetch entries.
`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 16
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

package imem_fetch_pkg;
  localparam int INST_AW = `CFG_INST_ADDR_WIDTH;
  localparam int INST_DW = `CFG_INST_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [INST_DW-1:0] data;
    logic [INST_AW-1:0] addr;
  } fetch_entry_t;
endpackage

// File: rtl/imem_fetch_if.sv
// imem request/ack handshake plus the decode-side instruction stream.
interface imem_fetch_if #(
  parameter int AW = imem_fetch_pkg::INST_AW,
  parameter int DW = imem_fetch_pkg::INST_DW
);
  logic          imem_req;
  logic [AW-1:0] imem_address;
  logic          imem_ack;
  logic [DW-1:0] imem_data_in;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_addr;
  logic          inst_ready;

  modport master (
    output imem_req, imem_address, inst_valid, inst_data, inst_addr,
    input  imem_ack, imem_data_in, inst_ready
  );

  modport slave (
    input  imem_req, imem_address, inst_valid, inst_data, inst_addr,
    output imem_ack, imem_data_in, inst_ready
  );
endinterface

// File: rtl/imem_fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush empties it in one cycle.
module imem_fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rptr, wptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign head = mem[rptr];
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, buffered results,
// redirects flush the buffer and drop any stale in-flight response.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH,
  parameter int FIFO_DEPTH      = 2,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_addr,
  imem_fetch_if.master               bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e               state, state_next;
  logic [INST_ADDR_WIDTH-1:0] pc, pc_next, req_addr, req_addr_next;
  logic [CW-1:0]              count, count_next;
  logic                       push, pop, can_issue;
  fetch_entry_t               wdata, head;

  // Redirect wins over everything: no push of the acked word, no pop of the head.
  assign push       = (state == REQ) && bus.imem_ack && !redirect_valid;
  assign pop        = bus.inst_valid && bus.inst_ready && !redirect_valid;
  assign count_next = count + CW'(push) - CW'(pop);
  assign can_issue  = fetch_en && (count_next < CW'(FIFO_DEPTH));

  assign wdata.data = bus.imem_data_in;
  assign wdata.addr = req_addr;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    if (redirect_valid) begin
      pc_next    = redirect_addr;
      state_next = (state != IDLE && !bus.imem_ack) ? DRAIN : IDLE;
    end else begin
      unique case (state)
        IDLE: if (can_issue) begin
          state_next    = REQ;
          req_addr_next = pc;
        end
        REQ: if (bus.imem_ack) begin
          pc_next = pc + 1'b1;
          if (can_issue) req_addr_next = pc + 1'b1;
          else           state_next    = IDLE;
        end
        // Stale response is swallowed here; pc already holds the redirect target.
        DRAIN: if (bus.imem_ack) begin
          if (can_issue) begin
            state_next    = REQ;
            req_addr_next = pc;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      req_addr <= RESET_ADDR;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  imem_fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign bus.imem_req     = (state != IDLE);
  assign bus.imem_address = req_addr;
  assign bus.inst_valid   = (count != '0);
  assign bus.inst_data    = head.data;
  assign bus.inst_addr    = head.addr;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle table for zero-wait fetch/backpressure/redirects,
// plus scoreboarded sequences for stale drain, PC wrap and reset mid-request.
module tb_imem_fetch_ctrl;
  import imem_fetch_pkg::*;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;

  imem_fetch_if #(.AW(AW), .DW(DW)) bus();

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;
  bit auto_ack = 1'b1;
  bit force_ack = 1'b0;
  bit sb_on = 1'b0;
  logic [AW-1:0] req_q[$];
  logic [AW-1:0] pop_q[$];

  function automatic logic [DW-1:0] mem_data(logic [AW-1:0] a);
    return {~a, a};
  endfunction

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Memory model: ack after 'lat' wait cycles (lat=0 acks the cycle req rises).
  assign bus.imem_ack     = force_ack | (auto_ack & bus.imem_req & (wait_cnt == lat));
  assign bus.imem_data_in = mem_data(bus.imem_address);
  always @(posedge clk) wait_cnt <= (!bus.imem_req || bus.imem_ack) ? 0 : wait_cnt + 1;

  // Scoreboard monitors: acked request addresses and popped instructions.
  always @(negedge clk) begin
    if (sb_on && !reset) begin
      if (bus.imem_req && bus.imem_ack && req_q.size() > 0)
        check("req_addr", 32'(bus.imem_address), 32'(req_q.pop_front()));
      if (bus.inst_valid && bus.inst_ready && !redirect_valid && pop_q.size() > 0) begin
        check("pop_data", bus.inst_data, mem_data(pop_q[0]));
        check("pop_addr", 32'(bus.inst_addr), 32'(pop_q.pop_front()));
      end
    end
  end

  typedef struct {
    bit en, rdy, rv;
    logic [AW-1:0] raddr;
    bit req;
    logic [AW-1:0] addr;
    bit vld;
    logic [AW-1:0] iaddr;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(bit en, bit rdy, bit rv, logic [AW-1:0] raddr,
                              bit req, logic [AW-1:0] addr, bit vld, logic [AW-1:0] iaddr);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.raddr = raddr;
    v.req = req; v.addr = addr; v.vld = vld; v.iaddr = iaddr;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    bus.inst_ready = 1'b0; force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_empty(string nm);
    int n = 0;
    while ((req_q.size() + pop_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drained"}, 32'(req_q.size() + pop_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.inst_ready = 1'b0;

    // Rows: inputs applied in a cycle, registered outputs expected in that cycle.
    tbl[0] = mk(1,1,0,0, 0,0,0,0);
    tbl[1] = mk(1,1,0,0, 1,0,0,0);
    for (int k = 2; k <= 8; k++) tbl[k] = mk(1,1,0,0, 1,AW'(k-1),1,AW'(k-2));
    tbl[9]  = mk(1,0,0,0,     1,8,1,7);
    tbl[10] = mk(1,0,0,0,     0,8,1,7);
    tbl[11] = mk(1,1,0,0,     0,8,1,7);
    tbl[12] = mk(1,1,0,0,     1,9,1,8);
    tbl[13] = mk(0,1,0,0,     1,10,1,9);
    tbl[14] = mk(0,1,0,0,     0,10,1,10);
    tbl[15] = mk(1,1,0,0,     0,10,0,0);
    tbl[16] = mk(1,1,0,0,     1,11,0,0);
    tbl[17] = mk(1,1,1,'h20,  1,12,1,11);
    tbl[18] = mk(1,1,0,0,     0,12,0,0);
    tbl[19] = mk(1,1,0,0,     1,'h20,0,0);
    tbl[20] = mk(0,1,0,0,     1,'h21,1,'h20);
    tbl[21] = mk(0,1,0,0,     0,'h21,1,'h21);
    tbl[22] = mk(0,1,1,'h30,  0,'h21,0,0);
    tbl[23] = mk(1,1,0,0,     0,'h21,0,0);
    tbl[24] = mk(0,1,0,0,     1,'h30,0,0);
    tbl[25] = mk(0,1,0,0,     0,'h30,1,'h30);
    tbl[26] = mk(0,1,0,0,     0,'h30,0,0);

    lat = 0; auto_ack = 1'b1; sb_on = 1'b0;
    do_reset();
    for (int i = 0; i < 27; i++) begin
      fetch_en       = tbl[i].en;
      bus.inst_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_addr  = tbl[i].raddr;
      @(negedge clk);
      check($sformatf("row%0d_req", i),   32'(bus.imem_req),     32'(tbl[i].req));
      check($sformatf("row%0d_addr", i),  32'(bus.imem_address), 32'(tbl[i].addr));
      check($sformatf("row%0d_valid", i), 32'(bus.inst_valid),   32'(tbl[i].vld));
      if (tbl[i].vld) begin
        check($sformatf("row%0d_iaddr", i), 32'(bus.inst_addr), 32'(tbl[i].iaddr));
        check($sformatf("row%0d_idata", i), bus.inst_data, mem_data(tbl[i].iaddr));
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;

    // Redirect while the request at 5 is still waiting on a 3-cycle memory.
    do_reset();
    lat = 3; sb_on = 1'b1;
    for (int k = 0; k <= 5; k++) req_q.push_back(AW'(k));
    for (int k = 0; k <= 4; k++) pop_q.push_back(AW'(k));
    for (int k = 'h40; k <= 'h42; k++) begin
      req_q.push_back(AW'(k));
      pop_q.push_back(AW'(k));
    end
    fetch_en = 1'b1; bus.inst_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_address == AW'(5)) found = 1'b1;
    end
    check("stale_req5_seen", 32'(found), 1);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_addr = 'h40;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) found = 1'b1;
    end
    check("stale_ack_seen", 32'(found), 1);
    @(negedge clk);
    check("stale_fifo_empty", 32'(bus.inst_valid), 0);
    check("stale_next_req", 32'(bus.imem_req), 1);
    check("stale_next_addr", 32'(bus.imem_address), 'h40);
    wait_empty("stale");

    // PC wrap from all-ones, redirect issued from IDLE.
    do_reset();
    lat = 0;
    req_q.push_back('1); req_q.push_back(0); req_q.push_back(1);
    pop_q.push_back('1); pop_q.push_back(0); pop_q.push_back(1);
    redirect_valid = 1'b1; redirect_addr = '1; bus.inst_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0; fetch_en = 1'b1;
    @(negedge clk);
    check("wrap_n1_req", 32'(bus.imem_req), 0);
    @(negedge clk);
    check("wrap_n2_req", 32'(bus.imem_req), 1);
    check("wrap_n2_addr", 32'(bus.imem_address), 32'h0000_FFFF);
    wait_empty("wrap");

    // Reset while a request hangs, then a late ack arriving in IDLE.
    do_reset();
    sb_on = 1'b0; auto_ack = 1'b0;
    fetch_en = 1'b1; bus.inst_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus.imem_req) found = 1'b1;
    end
    check("rst_req_up", 32'(found), 1);
    @(posedge clk); #1;
    reset = 1'b1; fetch_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_drop", 32'(bus.imem_req), 0);
    check("rst_valid", 32'(bus.inst_valid), 0);
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_valid", 32'(bus.inst_valid), 0);
    check("late_ack_req", 32'(bus.imem_req), 0);
    sb_on = 1'b1; lat = 0; auto_ack = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      req_q.push_back(AW'(k));
      pop_q.push_back(AW'(k));
    end
    @(posedge clk); #1;
    fetch_en = 1'b1;
    wait_empty("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
